// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through stream FIFO over a two-port synchronous block RAM, with a
// two-entry skid buffer hiding the RAM read latency. Optional level output: BRAM_FIFO_LEVEL_EN.
module bram_fifo_ctrl #(
  parameter int unsigned DATA = 8,
  parameter int unsigned ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  input  logic            out_ready,
  output logic            ram_a_we,
  output logic [ADDR-1:0] ram_a_addr,
  output logic [DATA-1:0] ram_a_write,
  output logic [ADDR-1:0] ram_b_addr,
  input  logic [DATA-1:0] ram_b_read
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR:0]   level
`endif
);

  localparam int unsigned CW = ADDR + 1;
  localparam logic [ADDR:0] RamDepth = {1'b1, {ADDR{1'b0}}};

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   ram_cnt_q, ram_cnt_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  logic [DATA-1:0] obuf0_q, obuf0_d;
  logic [DATA-1:0] obuf1_q, obuf1_d;

  logic       push, pop, fetch;
  logic [2:0] pend;

  assign in_ready    = !flush && (ram_cnt_q != RamDepth);
  assign out_valid   = (buf_cnt_q != 2'd0);
  assign out_data    = obuf0_q;
  assign ram_a_we    = push;
  assign ram_a_addr  = wr_ptr_q;
  assign ram_a_write = in_data;
  assign ram_b_addr  = rd_ptr_q;

  always_comb begin
    push = in_valid && in_ready;
    pop  = out_valid && out_ready && !flush;
    // Words already committed to the skid buffer once this cycle's pop is taken out.
    pend  = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    fetch = !flush && (ram_cnt_q != '0) && (pend < 3'd2);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    buf_cnt_d  = buf_cnt_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      buf_cnt_d = 2'd0;
    end else begin
      wr_ptr_d   = wr_ptr_q + ADDR'(push);
      rd_ptr_d   = rd_ptr_q + ADDR'(fetch);
      ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(fetch);
      inflight_d = fetch;
      if (pop) begin
        obuf0_d   = obuf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      // The returning word lands behind whatever survives this cycle's pop.
      if (inflight_q) begin
        if (buf_cnt_d == 2'd0) begin
          obuf0_d = ram_b_read;
        end else begin
          obuf1_d = ram_b_read;
        end
        buf_cnt_d = buf_cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
    end
  end

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= ram_cnt_d + CW'(inflight_d) + CW'(buf_cnt_d);
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl (ADDR=4) with a behavioural RAM and a queue
// scoreboard; level checks follow BRAM_FIFO_LEVEL_EN.
module tb_bram_fifo_ctrl;

  localparam int unsigned DATA = 8;
  localparam int unsigned ADDR = 4;

  logic            clk, rst_n, flush;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [DATA-1:0] in_data, out_data;
  logic            ram_a_we;
  logic [ADDR-1:0] ram_a_addr, ram_b_addr;
  logic [DATA-1:0] ram_a_write, ram_b_read;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR:0]   level;
`endif

  bram_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ram_a_we   (ram_a_we),
    .ram_a_addr (ram_a_addr),
    .ram_a_write(ram_a_write),
    .ram_b_addr (ram_b_addr),
    .ram_b_read (ram_b_read)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  // Two-port synchronous RAM, one-clock read latency.
  logic [DATA-1:0] mem [1 << ADDR];
  always @(posedge clk) begin
    if (ram_a_we) mem[ram_a_addr] <= ram_a_write;
    ram_b_read <= mem[ram_b_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int npush = 0;
  int npop = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [DATA-1:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at negedge+1; samples handshakes just before the edge, returns at the next negedge.
  task automatic tick();
    logic [DATA-1:0] exp_d;
    #3;
    if (flush) begin
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        npush++;
      end
      if (out_valid && out_ready) begin
        check("pop_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          check("pop_data", 32'(out_data), 32'(exp_d));
        end
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic            iv;
    logic [DATA-1:0] id;
    logic            ordy;
    logic            fl;
    logic            ov;
    logic [DATA-1:0] od;
    logic            ir;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int accepted;
    logic seen, got;

    // Cycle-by-cycle from empty: {in_valid, in_data, out_ready, flush} -> {out_valid, out_data, in_ready}
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ram_a_we", 32'(ram_a_we), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #1;
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle with data buffered
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i); #1; tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin #1; tick(); end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_ram_a_we", 32'(ram_a_we), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("midrst_level", 32'(level), 32'd0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Streaming 256 words through a 16-deep RAM: in order, no gaps, pointers wrap
    npop = 0; first_pop = -1; last_pop = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i); #1; tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin #1; tick(); end
    check("stream_count", 32'(npop), 32'd256);
    check("stream_no_gaps", 32'(last_pop - first_pop), 32'd255);
    check("stream_drained", 32'(q.size()), 32'd0);

    // Fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); #1;
      if (!in_ready) break;
      tick();
    end
    accepted = q.size();
    check("fill_accepted", 32'(accepted), 32'd18);
`ifdef BRAM_FIFO_LEVEL_EN
    check("fill_level", 32'(level), 32'd18);
`endif
    in_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (in_ready) seen = 1'b1;
      tick();
      if (seen) break;
    end
    check("fill_ready_again", 32'(seen), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin #1; tick(); end
    check("fill_drained", 32'(q.size()), 32'd0);

    // Flush with 10 words stored and a fetch in flight
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i); #1; tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    out_ready = 1'b1; #1; tick();
    out_ready = 1'b0; flush = 1'b1; #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("flush_level", 32'(level), 32'd0);
`endif
    in_valid = 1'b1; in_data = 8'h3C; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        check("flush_first_out", 32'(out_data), 32'h3C);
        tick();
        break;
      end
      tick();
    end
    check("flush_out_seen", 32'(got), 32'd1);

    // Random producer/consumer backpressure, 1000 words
    out_ready = 1'b0;
    npush = 0; npop = 0;
    for (int i = 0; i < 20000 && npop < 1000; i++) begin
      in_valid = (npush < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
`ifdef BRAM_FIFO_LEVEL_EN
      check("rand_level", 32'(level), 32'(q.size()));
`endif
      tick();
    end
    check("rand_pushed", 32'(npush), 32'd1000);
    check("rand_popped", 32'(npop), 32'd1000);
    check("rand_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
